// File: rtl/btb_assoc.sv
// N-way set-associative branch target buffer. It is looked up with the IF PC and
// trained by branches that resolve in ID. Replacement uses true LRU.
module btb_assoc #(
  parameter int unsigned SETS_LOG2 = 9,
  parameter int unsigned WAYS      = 2,
  parameter bit          EVICT_NT  = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] Instr_PC_IN_IF,
  input  logic [31:0] Instr_PC_IN_ID,
  input  logic        is_Branch_IN_ID,
  input  logic        is_Taken_IN_ID,
  input  logic [31:0] Alt_PC_IN_ID,
  output logic        hit_BTB,
  output logic [31:0] take_Alt_PC_OUT_IF
);

  localparam int unsigned TAG_W = 30 - SETS_LOG2;
  localparam int unsigned SETS  = 1 << SETS_LOG2;
  // When WAYS is 1, the age field is held at a 1-bit constant zero.
  localparam int unsigned AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WAYS - 1);

  logic [WAYS-1:0]  valid_q [SETS];
  logic [AGE_W-1:0] age_q   [SETS][WAYS];
  logic [TAG_W-1:0] tag_mem [SETS][WAYS];
  logic [31:0]      tgt_mem [SETS][WAYS];

  logic [SETS_LOG2-1:0] if_idx, id_idx;
  logic [TAG_W-1:0]     if_tag, id_tag;
  logic                 if_hit, id_hit, vic_inv_found, train_en, train_wr;
  logic [AGE_W-1:0]     if_way, id_way, vic_inv, vic_lru, wr_way;
  logic                 unused_pc;

  assign if_idx    = Instr_PC_IN_IF[SETS_LOG2+1:2];
  assign if_tag    = Instr_PC_IN_IF[31:SETS_LOG2+2];
  assign id_idx    = Instr_PC_IN_ID[SETS_LOG2+1:2];
  assign id_tag    = Instr_PC_IN_ID[31:SETS_LOG2+2];
  assign unused_pc = ^{Instr_PC_IN_IF[1:0], Instr_PC_IN_ID[1:0]};

  // Tag match for the IF and ID PCs. The loop runs downward so the lowest matching way wins.
  always_comb begin
    if_hit = 1'b0;
    if_way = '0;
    id_hit = 1'b0;
    id_way = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (valid_q[if_idx][i] && (tag_mem[if_idx][i] == if_tag)) begin
        if_hit = 1'b1;
        if_way = AGE_W'(i);
      end
      if (valid_q[id_idx][i] && (tag_mem[id_idx][i] == id_tag)) begin
        id_hit = 1'b1;
        id_way = AGE_W'(i);
      end
    end
  end

  // Victim choice: the lowest invalid way, otherwise the LRU way (age WAYS-1).
  always_comb begin
    vic_inv_found = 1'b0;
    vic_inv       = '0;
    vic_lru       = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (!valid_q[id_idx][i]) begin
        vic_inv_found = 1'b1;
        vic_inv       = AGE_W'(i);
      end
      if (age_q[id_idx][i] == AGE_MAX) vic_lru = AGE_W'(i);
    end
    wr_way = id_hit ? id_way : (vic_inv_found ? vic_inv : vic_lru);
  end

  assign train_en = !STALL && !FLUSH && is_Branch_IN_ID;
  assign train_wr = train_en && is_Taken_IN_ID;

  // Valid bits and LRU ages. A flush restores the reset state in a single cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET || FLUSH) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        for (int i = 0; i < int'(WAYS); i++) age_q[s][i] <= AGE_W'(i);
      end
    end else if (train_en) begin
      if (is_Taken_IN_ID) begin
        valid_q[id_idx][wr_way] <= 1'b1;
        for (int i = 0; i < int'(WAYS); i++) begin
          if (AGE_W'(i) == wr_way) begin
            age_q[id_idx][i] <= '0;
          end else if (age_q[id_idx][i] < age_q[id_idx][wr_way]) begin
            age_q[id_idx][i] <= age_q[id_idx][i] + 1'b1;
          end
        end
      end else if (EVICT_NT && id_hit) begin
        valid_q[id_idx][id_way] <= 1'b0;
      end
    end
  end

  // Tag and target storage. These arrays are not reset, because the valid bits gate every hit.
  always_ff @(posedge CLK) begin
    if (train_wr) begin
      tag_mem[id_idx][wr_way] <= id_tag;
      tgt_mem[id_idx][wr_way] <= Alt_PC_IN_ID;
    end
  end

  // Registered lookup. It reads the contents from before any training write in the same cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_BTB            <= 1'b0;
      take_Alt_PC_OUT_IF <= '0;
    end else if (FLUSH) begin
      hit_BTB            <= 1'b0;
      take_Alt_PC_OUT_IF <= Instr_PC_IN_IF + 32'd4;
    end else if (!STALL) begin
      hit_BTB            <= if_hit;
      take_Alt_PC_OUT_IF <= if_hit ? tgt_mem[if_idx][if_way] : Instr_PC_IN_IF + 32'd4;
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc. Two instances share the same stimulus and differ only in EVICT_NT.
module tb_btb_assoc;

  logic        CLK = 1'b0;
  logic        RESET, STALL, FLUSH, is_Branch_IN_ID, is_Taken_IN_ID;
  logic [31:0] Instr_PC_IN_IF, Instr_PC_IN_ID, Alt_PC_IN_ID;
  logic        hit0, hit1;
  logic [31:0] out0, out1;
  int          n_tests = 0;
  int          n_fail  = 0;

  localparam logic [31:0] PcA = 32'h0040_0010;
  localparam logic [31:0] PcB = 32'h0040_0810;
  localparam logic [31:0] PcC = 32'h0040_1010;
  localparam logic [31:0] PcD = 32'h0040_2010;
  localparam logic [31:0] PcX = 32'h0000_0100;

  always #5 CLK = ~CLK;

  btb_assoc #(.SETS_LOG2(9), .WAYS(2), .EVICT_NT(1'b0)) dut0 (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .Instr_PC_IN_IF(Instr_PC_IN_IF), .Instr_PC_IN_ID(Instr_PC_IN_ID),
    .is_Branch_IN_ID(is_Branch_IN_ID), .is_Taken_IN_ID(is_Taken_IN_ID),
    .Alt_PC_IN_ID(Alt_PC_IN_ID), .hit_BTB(hit0), .take_Alt_PC_OUT_IF(out0)
  );

  btb_assoc #(.SETS_LOG2(9), .WAYS(2), .EVICT_NT(1'b1)) dut1 (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .Instr_PC_IN_IF(Instr_PC_IN_IF), .Instr_PC_IN_ID(Instr_PC_IN_ID),
    .is_Branch_IN_ID(is_Branch_IN_ID), .is_Taken_IN_ID(is_Taken_IN_ID),
    .Alt_PC_IN_ID(Alt_PC_IN_ID), .hit_BTB(hit1), .take_Alt_PC_OUT_IF(out1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    Instr_PC_IN_IF  = pc;
    is_Branch_IN_ID = 1'b0;
    tick();
  endtask

  task automatic train(input logic [31:0] if_pc, input logic [31:0] pc, input logic taken,
                       input logic [31:0] tgt);
    Instr_PC_IN_IF  = if_pc;
    Instr_PC_IN_ID  = pc;
    is_Taken_IN_ID  = taken;
    Alt_PC_IN_ID    = tgt;
    is_Branch_IN_ID = 1'b1;
    tick();
    is_Branch_IN_ID = 1'b0;
  endtask

  initial begin
    RESET = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
    is_Branch_IN_ID = 1'b0; is_Taken_IN_ID = 1'b0;
    Instr_PC_IN_IF = '0; Instr_PC_IN_ID = '0; Alt_PC_IN_ID = '0;
    #2;
    chk("reset_hit", {31'b0, hit0}, 32'd0);
    chk("reset_out", out0, 32'd0);
    #10 RESET = 1'b1;

    // Miss on an empty BTB, followed by a miss that wraps PC+4 past 2^32.
    lookup(PcA);
    chk("miss_hit", {31'b0, hit0}, 32'd0);
    chk("miss_out", out0, 32'h0040_0014);
    lookup(32'hFFFF_FFFC);
    chk("wrap_out", out0, 32'h0000_0000);

    // Train A while also looking up A: this cycle reads the old contents, the next one hits.
    train(PcA, PcA, 1'b1, 32'h0040_0100);
    chk("rbw_hit", {31'b0, hit0}, 32'd0);
    chk("rbw_out", out0, 32'h0040_0014);
    lookup(PcA);
    chk("trainA_hit", {31'b0, hit0}, 32'd1);
    chk("trainA_out", out0, 32'h0040_0100);

    // Fill set 4 with B, make A MRU again, then insert C. C must evict B.
    train(PcX, PcB, 1'b1, 32'h0040_0900);
    train(PcX, PcA, 1'b1, 32'h0040_0100);
    train(PcX, PcC, 1'b1, 32'h0040_1100);
    lookup(PcA);
    chk("lruA_hit", {31'b0, hit0}, 32'd1);
    chk("lruA_out", out0, 32'h0040_0100);
    lookup(PcC);
    chk("lruC_hit", {31'b0, hit0}, 32'd1);
    chk("lruC_out", out0, 32'h0040_1100);
    lookup(PcB);
    chk("lruB_hit", {31'b0, hit0}, 32'd0);
    chk("lruB_out", out0, 32'h0040_0814);

    // A taken re-hit refreshes the stored target.
    train(PcX, PcA, 1'b1, 32'h0040_0200);
    lookup(PcA);
    chk("refresh_out", out0, 32'h0040_0200);
    chk("refresh1_out", out1, 32'h0040_0200);

    // A not-taken resolution evicts only in the EVICT_NT=1 instance.
    train(PcX, PcA, 1'b0, 32'h0);
    lookup(PcA);
    chk("nt0_hit", {31'b0, hit0}, 32'd1);
    chk("nt0_out", out0, 32'h0040_0200);
    chk("nt1_hit", {31'b0, hit1}, 32'd0);
    chk("nt1_out", out1, 32'h0040_0014);

    // While STALL is high, training is blocked and the outputs hold.
    lookup(PcC);
    STALL = 1'b1;
    train(PcA, PcD, 1'b1, 32'h0040_2100);
    chk("stall_hit", {31'b0, hit0}, 32'd1);
    chk("stall_out", out0, 32'h0040_1100);
    STALL = 1'b0;
    lookup(PcD);
    chk("stallD_hit", {31'b0, hit0}, 32'd0);
    chk("stallD_out", out0, 32'h0040_2014);
    lookup(PcC);
    chk("stallC_hit", {31'b0, hit0}, 32'd1);

    // FLUSH forces a miss in the same cycle and clears every entry.
    FLUSH = 1'b1;
    lookup(PcC);
    chk("flush_hit", {31'b0, hit0}, 32'd0);
    chk("flush_out", out0, 32'h0040_1014);
    FLUSH = 1'b0;
    lookup(PcA);
    chk("flushA_hit", {31'b0, hit0}, 32'd0);
    lookup(PcC);
    chk("flushC_hit", {31'b0, hit0}, 32'd0);

    // An asynchronous reset in the middle of the run clears the outputs before the next edge.
    train(PcX, PcA, 1'b1, 32'h0040_0100);
    lookup(PcA);
    chk("pre_rst_hit", {31'b0, hit0}, 32'd1);
    #2 RESET = 1'b0;
    #1;
    chk("async_rst_hit", {31'b0, hit0}, 32'd0);
    chk("async_rst_out", out0, 32'd0);
    #2 RESET = 1'b1;
    lookup(PcA);
    chk("post_rst_hit", {31'b0, hit0}, 32'd0);
    chk("post_rst_out", out0, 32'h0040_0014);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
